fanin_link_arb: RTL and testbench
=================================

# fanin_link_arb

Parametrised fan-in link arbiter: merges NUM_LINK input links onto one output per channel, for NUM_CHANNEL independent channels.
- Each link/channel pair has a DEPTH_FIFO-entry token FIFO.
- A per-channel arbiter grants one link for a whole message, from acquire token to release token.
- Arbitration is round-robin or fixed-priority.
- Orphan tokens are detected and reported.
- Output is a registered, back-pressured stage.

The block sits between the router link outputs and a compute-element input port. It replaces the single-depth, round-robin-only fan-in.

## Interface
Parameters:
- WIDTH_DATA, 32, payload width of FTk_t.d
- NUM_LINK, 4, input links per channel (≥2)
- NUM_CHANNEL, 1, independent channels
- DEPTH_FIFO, 4, entries per link FIFO (power of two, ≥2)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest link index wins)
- TYPE_FTK, FTk_t, forward token: v valid, a acquire (message head), r release (message tail), d data
- TYPE_BTK, BTk_t, back token: n nack (hold)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- I_FTk  in  [NUM_LINK][NUM_CHANNEL] TYPE_FTK  link forward tokens
- O_BTk  out  [NUM_LINK][NUM_CHANNEL] TYPE_BTK  link nack, n = FIFO full
- O_FTk  out  [NUM_CHANNEL] TYPE_FTK  merged forward tokens, registered
- I_BTk  in  [NUM_CHANNEL] TYPE_BTK  downstream nack
- O_GrtNo  out  [NUM_CHANNEL][$clog2(NUM_LINK)]  currently or last granted link
- O_Lock  out  [NUM_CHANNEL]  channel is in LOCK state
- O_Orphan  out  [NUM_CHANNEL]  sticky flag: orphan token discarded

## Operation
FIFOs:
- Push when I_FTk.v=1 and the FIFO is not full. A push while full is ignored; senders must hold while n=1.
- O_BTk.n is driven combinationally from the registered full flag.
- Push and pop in the same cycle leave the count unchanged; a pop from empty never occurs.
- Pointers wrap modulo DEPTH_FIFO. The count is $clog2(DEPTH_FIFO)+1 bits wide.

Per-channel FSM, states IDLE and LOCK:
- Output stage "ready" = output register empty, or (O_FTk.v=1 and I_BTk.n=0).
- IDLE, candidates: links whose FIFO head has v=1 and a=1.
- IDLE, no ready: nothing moves.
- IDLE, ready and at least one candidate: select the winner. Round-robin searches upward from pointer P with wrap; fixed priority picks the lowest index. Pop the winner's head into the output register and set O_GrtNo.
- IDLE, head had r=1 (single-token message): stay IDLE; P ← winner+1 mod NUM_LINK.
- IDLE, head had r=0: go to LOCK.
- IDLE, orphan heads: any non-candidate head with v=1 and a=0 is popped and discarded that cycle, and O_Orphan[c] ← 1. This happens regardless of ready.
- LOCK: the granted FIFO head is forwarded one token per ready cycle. Other links' heads wait; they are not checked for orphans.
- LOCK: a forwarded token with r=1 returns the FSM to IDLE, with P ← grant+1 mod NUM_LINK.
- LOCK: an a=1 token arriving mid-message is forwarded unchanged; it is not an error.

Output register:
- Loads when ready and a token is selected.
- Clears v when ready and nothing is selected.
- Holds its contents while I_BTk.n=1.

Reset (reset=0), asynchronous for all registers:
- FIFOs empty; O_BTk.n=0; O_FTk='0; FSM IDLE; P=0; O_GrtNo=0; O_Lock=0; O_Orphan=0.
- Mid-message reset drops all in-flight tokens. There is no partial-message recovery.

## Timing
- Latency: token presented in cycle 0 → written at edge 1 → popped and registered at edge 2 → O_FTk.v=1 in cycle 2.
- Throughput: one token per cycle per channel in LOCK with I_BTk.n=0. Back-to-back messages from different links have no bubble.
- O_BTk.n rises in the cycle after the write that fills the FIFO. The sender may already have presented one more token; that token is ignored, and the sender must retry.
- Full FIFO with simultaneous pop: n stays 1 that cycle and falls the next.
- O_Lock and O_GrtNo update at the same edge as the first-token pop.

## Structure
- pkg_en holds FTk_t/BTk_t (fields v,a,r,d / n) and the localparams ARB_RR=0, ARB_FIX=1.
- Sub-module fanin_link_fifo: one instance per link/channel. It contains the storage, head view, pop input, and full/empty outputs.
- The arbiter, FSM, and output register live inline in a generate over channels.

## Test plan
- NUM_LINK=4, DEPTH_FIFO=4, RR mode:
  - Links 0–3 each send a 3-token message in cycle 0 → output order link0, link1, link2, link3. Tokens are contiguous per message; 12 tokens in cycles 2–13.
  - Link 2 sends a single token (a=r=1, d=0xA5) → O_FTk.v=1 in cycle 2 with d=0xA5; O_Lock stays 0; next RR search starts at link 3.
- ARB_MODE=1, links 3 and 1 request simultaneously → link 1 wins. Link 3 waits until link 1's r=1 token leaves.
- I_BTk.n held 1 for 10 cycles while link 0 streams 8 tokens:
  - O_FTk is stable throughout.
  - O_BTk[0].n=1 after 4+1 tokens are buffered.
  - No token is lost or duplicated after release.
- Link 1 head is v=1, a=0 while IDLE → the token is discarded and O_Orphan=1 the next cycle. A subsequent valid message still passes.
- Assert reset during the 2nd token of a 5-token message → all outputs 0 immediately. After release the FSM is IDLE and FIFOs are empty.

Source files
------------

// File: rtl/pkg_en.sv
// Shared types for the fan-in link arbiter.
//   FTk_t     : forward token (v valid, a acquire/head, r release/tail, d data)
//   BTk_t     : back token (n nack/hold)
//   ARB_RR    : round-robin arbitration
//   ARB_FIX   : fixed priority, lowest link index wins
//   arb_st_e  : per-channel arbiter state
package pkg_en;

    localparam int WIDTH_DATA_DEF = 32;

    localparam int ARB_RR  = 0;
    localparam int ARB_FIX = 1;

    typedef struct packed {
        logic                      v;
        logic                      a;
        logic                      r;
        logic [WIDTH_DATA_DEF-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
    } BTk_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_st_e;

endpackage

// File: rtl/fanin_link_fifo.sv
// Token FIFO for one link/channel pair.
// Ports:
//   clock, reset : clock, asynchronous active-low reset
//   push, wdata  : write request; dropped when full
//   pop          : consume the head (caller never pops when empty)
//   head         : current head entry (meaningful when !empty)
//   full, empty  : decoded from the registered occupancy count
module fanin_link_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wp, rp;
    logic [AW:0]                 cnt;
    logic                        wr;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    // A push against a full FIFO is ignored even if a pop frees a slot
    // this cycle; the sender sees n=1 and retries.
    assign wr    = push & ~full;
    assign head  = mem[rp];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            if (wr && !pop)      cnt <= cnt + 1'b1;
            else if (!wr && pop) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/fanin_link_arb.sv
// Fan-in link arbiter: merges NUM_LINK links onto one registered,
// back-pressured output per channel. A grant is held for a whole message
// (acquire token through release token).
// Ports:
//   clock, reset : clock, asynchronous active-low reset
//   I_FTk/O_BTk  : per link/channel forward tokens in, FIFO-full nack out
//   O_FTk/I_BTk  : per channel merged tokens out (registered), downstream nack in
//   O_GrtNo      : current or last granted link per channel
//   O_Lock       : channel is mid-message
//   O_Orphan     : sticky, a headless token was discarded
module fanin_link_arb
    import pkg_en::*;
#(
    parameter int  WIDTH_DATA  = 32,
    parameter int  NUM_LINK    = 4,
    parameter int  NUM_CHANNEL = 1,
    parameter int  DEPTH_FIFO  = 4,
    parameter int  ARB_MODE    = ARB_RR,
    parameter type TYPE_FTK    = FTk_t,
    parameter type TYPE_BTK    = BTk_t
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  TYPE_FTK [NUM_LINK-1:0][NUM_CHANNEL-1:0]       I_FTk,
    output TYPE_BTK [NUM_LINK-1:0][NUM_CHANNEL-1:0]       O_BTk,
    output TYPE_FTK [NUM_CHANNEL-1:0]                     O_FTk,
    input  TYPE_BTK [NUM_CHANNEL-1:0]                     I_BTk,
    output logic [NUM_CHANNEL-1:0][$clog2(NUM_LINK)-1:0]  O_GrtNo,
    output logic [NUM_CHANNEL-1:0]                        O_Lock,
    output logic [NUM_CHANNEL-1:0]                        O_Orphan
);

    localparam int LW = $clog2(NUM_LINK);
    localparam int WF = WIDTH_DATA + 2;   // stored {a, r, d}; v is implied by !empty

    function automatic TYPE_BTK mk_btk(input logic n);
        TYPE_BTK b;
        b   = '0;
        b.n = n;
        return b;
    endfunction

    function automatic logic [LW-1:0] nxt(input logic [LW-1:0] g);
        return LW'((int'(g) + 1) % NUM_LINK);
    endfunction

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
        logic    [NUM_LINK-1:0]         full, empty, pop, cand, orph;
        logic    [NUM_LINK-1:0][WF-1:0] head;
        TYPE_FTK [NUM_LINK-1:0]         hd;

        arb_st_e       st_q, st_d;
        logic [LW-1:0] ptr_q, ptr_d, grt_q, grt_d, win;
        logic          found, ready, sel, orph_q, orph_d;
        TYPE_FTK       out_q, tok;

        for (genvar l = 0; l < NUM_LINK; l++) begin : g_lk
            fanin_link_fifo #(.WIDTH(WF), .DEPTH(DEPTH_FIFO)) u_fifo (
                .clock (clock),
                .reset (reset),
                .push  (I_FTk[l][c].v),
                .wdata ({I_FTk[l][c].a, I_FTk[l][c].r, I_FTk[l][c].d}),
                .pop   (pop[l]),
                .head  (head[l]),
                .full  (full[l]),
                .empty (empty[l])
            );
            assign O_BTk[l][c] = mk_btk(full[l]);
        end

        always_comb begin
            for (int l = 0; l < NUM_LINK; l++) begin
                hd[l]   = '0;
                hd[l].v = ~empty[l];
                {hd[l].a, hd[l].r, hd[l].d} = head[l];
                cand[l] = hd[l].v &  hd[l].a;
                orph[l] = hd[l].v & ~hd[l].a;
            end
        end

        // Winner search: round-robin scans upward from ptr_q with wrap,
        // fixed priority scans from link 0.
        always_comb begin
            int            idx;
            logic [LW-1:0] il;
            found = 1'b0;
            win   = '0;
            for (int k = 0; k < NUM_LINK; k++) begin
                idx = (ARB_MODE == ARB_FIX) ? k : (int'(ptr_q) + k) % NUM_LINK;
                il  = LW'(idx);
                if (!found && cand[il]) begin
                    found = 1'b1;
                    win   = il;
                end
            end
        end

        assign ready = ~out_q.v | ~I_BTk[c].n;

        always_comb begin
            st_d   = st_q;
            ptr_d  = ptr_q;
            grt_d  = grt_q;
            orph_d = orph_q;
            pop    = '0;
            sel    = 1'b0;
            tok    = hd[grt_q];
            if (st_q == ST_IDLE) begin
                // Headless tokens are flushed in IDLE whether or not the
                // output can accept anything this cycle.
                pop = orph;
                if (|orph) orph_d = 1'b1;
                if (ready && found) begin
                    sel      = 1'b1;
                    tok      = hd[win];
                    grt_d    = win;
                    pop[win] = 1'b1;
                    if (hd[win].r) ptr_d = nxt(win);
                    else           st_d  = ST_LOCK;
                end
            end else if (ready && hd[grt_q].v) begin
                sel        = 1'b1;
                pop[grt_q] = 1'b1;
                if (hd[grt_q].r) begin
                    st_d  = ST_IDLE;
                    ptr_d = nxt(grt_q);
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                st_q   <= ST_IDLE;
                ptr_q  <= '0;
                grt_q  <= '0;
                orph_q <= 1'b0;
                out_q  <= '0;
            end else begin
                st_q   <= st_d;
                ptr_q  <= ptr_d;
                grt_q  <= grt_d;
                orph_q <= orph_d;
                if (sel)        out_q   <= tok;
                else if (ready) out_q.v <= 1'b0;
            end
        end

        assign O_FTk[c]    = out_q;
        assign O_GrtNo[c]  = grt_q;
        assign O_Lock[c]   = (st_q == ST_LOCK);
        assign O_Orphan[c] = orph_q;
    end

endmodule

// File: tb/tb_fanin_link_arb.sv
// Bench for fanin_link_arb: two DUTs (2-channel round-robin, 1-channel
// fixed priority) driven by per-link sender queues and compared every
// cycle against a queue-based reference model; directed scenarios add
// checks against hand-derived constants.
module tb_fanin_link_arb;
    import pkg_en::*;

    localparam int NL = 4;
    localparam int DP = 4;
    localparam int NU = 3;   // units 0,1: RR channels; unit 2: fixed-priority channel

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    FTk_t [NL-1:0][1:0] rr_ift;
    BTk_t [NL-1:0][1:0] rr_obt;
    FTk_t [1:0]         rr_oft;
    BTk_t [1:0]         rr_ibt;
    logic [1:0][1:0]    rr_grt;
    logic [1:0]         rr_lock, rr_orph;

    FTk_t [NL-1:0][0:0] fx_ift;
    BTk_t [NL-1:0][0:0] fx_obt;
    FTk_t [0:0]         fx_oft;
    BTk_t [0:0]         fx_ibt;
    logic [0:0][1:0]    fx_grt;
    logic [0:0]         fx_lock, fx_orph;

    fanin_link_arb #(.WIDTH_DATA(32), .NUM_LINK(NL), .NUM_CHANNEL(2), .DEPTH_FIFO(DP),
                     .ARB_MODE(ARB_RR)) dut_rr (
        .clock(clock), .reset(reset), .I_FTk(rr_ift), .O_BTk(rr_obt), .O_FTk(rr_oft),
        .I_BTk(rr_ibt), .O_GrtNo(rr_grt), .O_Lock(rr_lock), .O_Orphan(rr_orph));

    fanin_link_arb #(.WIDTH_DATA(32), .NUM_LINK(NL), .NUM_CHANNEL(1), .DEPTH_FIFO(DP),
                     .ARB_MODE(ARB_FIX)) dut_fx (
        .clock(clock), .reset(reset), .I_FTk(fx_ift), .O_BTk(fx_obt), .O_FTk(fx_oft),
        .I_BTk(fx_ibt), .O_GrtNo(fx_grt), .O_Lock(fx_lock), .O_Orphan(fx_orph));

    // reference model state
    FTk_t mq[NU][NL][$];    // link FIFO contents
    FTk_t sq[NU][NL][$];    // tokens each sender still has to deliver
    FTk_t pres[NU][NL];
    FTk_t mout[NU];
    bit   bn[NU];
    int   mlock[NU];        // -1 when idle, else the locked link
    int   mptr[NU], mgrt[NU];
    bit   morph[NU];

    int   n_chk, n_err;
    int   cyc, pres_pct, bn_pct, bp_force;
    bit   rec;
    int   gc[NU][$];
    logic [31:0] gd[NU][$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic FTk_t mk(input bit a, input bit r, input logic [31:0] d);
        FTk_t t;
        t.v = 1'b1; t.a = a; t.r = r; t.d = d;
        return t;
    endfunction

    function automatic FTk_t o_ftk(input int u);
        return (u == 2) ? fx_oft[1'b0] : rr_oft[1'(u)];
    endfunction

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            for (int l = 0; l < NL; l++) begin
                mq[u][l].delete();
                sq[u][l].delete();
                pres[u][l] = '0;
            end
            mout[u] = '0; bn[u] = 1'b0; mlock[u] = -1;
            mptr[u] = 0;  mgrt[u] = 0;  morph[u] = 1'b0;
            gc[u].delete(); gd[u].delete();
        end
    endtask

    task automatic apply();
        for (int l = 0; l < NL; l++) begin
            rr_ift[2'(l)][1'b0] = pres[0][l];
            rr_ift[2'(l)][1'b1] = pres[1][l];
            fx_ift[2'(l)][1'b0] = pres[2][l];
        end
        rr_ibt[1'b0].n = bn[0];
        rr_ibt[1'b1].n = bn[1];
        fx_ibt[1'b0].n = bn[2];
    endtask

    task automatic drive();
        FTk_t ft;
        for (int u = 0; u < NU; u++) begin
            for (int l = 0; l < NL; l++)
                pres[u][l] = (sq[u][l].size() > 0 && $urandom_range(99) < pres_pct) ? sq[u][l][0] : '0;
            bn[u] = (bp_force > 0) || ($urandom_range(99) < bn_pct);
            ft = o_ftk(u);
            if (rec && ft.v && !bn[u]) begin
                gc[u].push_back(cyc);
                gd[u].push_back(ft.d);
            end
        end
        apply();
    endtask

    task automatic step(input int u);
        bit   full[NL], cand[NL], orp[NL];
        bit   ready;
        int   w, g, l;
        FTk_t t;
        ready = !mout[u].v || !bn[u];
        for (int k = 0; k < NL; k++) begin
            full[k] = (mq[u][k].size() == DP);
            cand[k] = (mq[u][k].size() > 0) &&  mq[u][k][0].a;
            orp[k]  = (mq[u][k].size() > 0) && !mq[u][k][0].a;
        end
        if (mlock[u] < 0) begin
            w = -1;
            if (ready)
                for (int k = 0; k < NL; k++) begin
                    l = (u == 2) ? k : (mptr[u] + k) % NL;
                    if (w < 0 && cand[l]) w = l;
                end
            for (int k = 0; k < NL; k++)
                if (orp[k]) begin
                    void'(mq[u][k].pop_front());
                    morph[u] = 1'b1;
                end
            if (w >= 0) begin
                t = mq[u][w].pop_front();
                mout[u] = t;
                mgrt[u] = w;
                if (t.r) mptr[u] = (w + 1) % NL;
                else     mlock[u] = w;
            end else if (ready) mout[u].v = 1'b0;
        end else begin
            g = mlock[u];
            if (ready && mq[u][g].size() > 0) begin
                t = mq[u][g].pop_front();
                mout[u] = t;
                if (t.r) begin
                    mlock[u] = -1;
                    mptr[u]  = (g + 1) % NL;
                end
            end else if (ready) mout[u].v = 1'b0;
        end
        for (int k = 0; k < NL; k++)
            if (pres[u][k].v && !full[k]) begin
                mq[u][k].push_back(pres[u][k]);
                void'(sq[u][k].pop_front());
            end
    endtask

    task automatic check_all();
        logic [NL-1:0] bo, be;
        for (int u = 0; u < NU; u++) begin
            for (int l = 0; l < NL; l++) begin
                bo[2'(l)] = (u == 2) ? fx_obt[2'(l)][1'b0].n : rr_obt[2'(l)][1'(u)].n;
                be[2'(l)] = (mq[u][l].size() == DP);
            end
            chk($sformatf("ftk u%0d c%0d", u, cyc), 64'(o_ftk(u)), 64'(mout[u]));
            chk($sformatf("btk u%0d c%0d", u, cyc), 64'(bo), 64'(be));
            chk($sformatf("grt u%0d c%0d", u, cyc),
                64'((u == 2) ? fx_grt[1'b0] : rr_grt[1'(u)]), 64'(mgrt[u]));
            chk($sformatf("lock u%0d c%0d", u, cyc),
                64'((u == 2) ? fx_lock[1'b0] : rr_lock[1'(u)]), 64'(mlock[u] >= 0));
            chk($sformatf("orph u%0d c%0d", u, cyc),
                64'((u == 2) ? fx_orph[1'b0] : rr_orph[1'(u)]), 64'(morph[u]));
        end
    endtask

    task automatic tick();
        drive();
        @(posedge clock);
        for (int u = 0; u < NU; u++) step(u);
        if (bp_force > 0) bp_force--;
        #1;
        cyc++;
        check_all();
    endtask

    // Reset is asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        apply();
        #1;
        check_all();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cyc = 0;
        bp_force = 0;
    endtask

    task automatic gen(input int u, input int l);
        int len;
        if ($urandom_range(9) == 0) begin
            sq[u][l].push_back(mk(1'b0, 1'($urandom_range(1)), $urandom));
        end else begin
            len = 1 + $urandom_range(4);
            for (int i = 0; i < len; i++)
                sq[u][l].push_back(mk((i == 0) || ($urandom_range(15) == 0), i == len - 1, $urandom));
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; bp_force = 0; rec = 1'b0;
        pres_pct = 100; bn_pct = 0;
        model_reset();
        apply();
        #2;
        do_reset();

        // Directed: RR 4x3-token messages (unit 0), RR single token then
        // pointer check (unit 1), fixed priority 3 vs 1 (unit 2).
        for (int l = 0; l < NL; l++)
            for (int k = 0; k < 3; k++) sq[0][l].push_back(mk(k == 0, k == 2, 32'(16 * l + k)));
        sq[1][2].push_back(mk(1'b1, 1'b1, 32'hA5));
        for (int k = 0; k < 2; k++) begin
            sq[2][3].push_back(mk(k == 0, k == 1, 32'(8'h30 + k)));
            sq[2][1].push_back(mk(k == 0, k == 1, 32'(8'h10 + k)));
        end
        rec = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (t == 4) begin
                sq[1][1].push_back(mk(1'b1, 1'b1, 32'hB1));
                sq[1][3].push_back(mk(1'b1, 1'b1, 32'hB3));
            end
            tick();
            if (cyc == 2) chk("single lock", 64'(rr_lock[1]), 64'd0);
        end
        rec = 1'b0;
        chk("rr4 count", 64'(gd[0].size()), 64'd12);
        for (int i = 0; i < 12 && i < gd[0].size(); i++) begin
            chk($sformatf("rr4 d%0d", i), 64'(gd[0][i]), 64'((i / 3) * 16 + i % 3));
            chk($sformatf("rr4 cyc%0d", i), 64'(gc[0][i]), 64'(2 + i));
        end
        chk("rr1 count", 64'(gd[1].size()), 64'd3);
        if (gd[1].size() == 3) begin
            chk("rr1 A5", {32'(gc[1][0]), gd[1][0]}, {32'd2, 32'hA5});
            chk("rr1 B3", {32'(gc[1][1]), gd[1][1]}, {32'd6, 32'hB3});
            chk("rr1 B1", {32'(gc[1][2]), gd[1][2]}, {32'd7, 32'hB1});
        end
        chk("fix count", 64'(gd[2].size()), 64'd4);
        if (gd[2].size() == 4) begin
            chk("fix 0", {32'(gc[2][0]), gd[2][0]}, {32'd2, 32'h10});
            chk("fix 1", {32'(gc[2][1]), gd[2][1]}, {32'd3, 32'h11});
            chk("fix 2", {32'(gc[2][2]), gd[2][2]}, {32'd4, 32'h30});
            chk("fix 3", {32'(gc[2][3]), gd[2][3]}, {32'd5, 32'h31});
        end

        // Directed: orphan on link 1, then a valid message still passes.
        do_reset();
        sq[0][1].push_back(mk(1'b0, 1'b0, 32'h77));
        sq[0][1].push_back(mk(1'b1, 1'b1, 32'h78));
        for (int t = 0; t < 5; t++) begin
            tick();
            if (cyc == 1) chk("orphan pre", 64'(rr_orph[0]), 64'd0);
            if (cyc == 2) chk("orphan set", 64'(rr_orph[0]), 64'd1);
            if (cyc == 3) chk("after orphan", 64'(rr_oft[0]), 64'(mk(1'b1, 1'b1, 32'h78)));
        end

        // Directed: downstream hold for 10 cycles while link 0 streams 8 tokens.
        do_reset();
        for (int k = 0; k < 8; k++) sq[0][0].push_back(mk(k == 0, k == 7, 32'(8'hC0 + k)));
        bp_force = 10;
        rec = 1'b1;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (cyc >= 2 && cyc <= 10) chk($sformatf("bp hold c%0d", cyc), 64'(rr_oft[0]), 64'(mk(1'b1, 1'b0, 32'hC0)));
            if (cyc == 4) chk("bp n low", 64'(rr_obt[0][0].n), 64'd0);
            if (cyc == 5) chk("bp n high", 64'(rr_obt[0][0].n), 64'd1);
        end
        rec = 1'b0;
        chk("bp count", 64'(gd[0].size()), 64'd8);
        for (int i = 0; i < 8 && i < gd[0].size(); i++)
            chk($sformatf("bp d%0d", i), 64'(gd[0][i]), 64'(8'hC0 + i));

        // Directed: reset in the middle of a 5-token message.
        do_reset();
        for (int k = 0; k < 5; k++) sq[0][2].push_back(mk(k == 0, k == 4, 32'(8'hD0 + k)));
        for (int t = 0; t < 3; t++) tick();
        chk("mid lock", 64'(rr_lock[0]), 64'd1);
        do_reset();
        for (int t = 0; t < 3; t++) tick();

        // Random traffic with random back-pressure, bursts and a mid-run reset.
        pres_pct = 70; bn_pct = 25;
        for (int t = 0; t < 1500; t++) begin
            for (int u = 0; u < NU; u++)
                for (int l = 0; l < NL; l++)
                    if (sq[u][l].size() == 0 && $urandom_range(3) == 0) gen(u, l);
            if (t % 300 == 150) bp_force = 10;
            if (t == 700) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
